// File: rtl/input_port.sv
// Synchronised, debounced push-button / slide-switch front end with a one-entry
// valid/ready holding register. Define INPUT_PORT_OVERRUN_EN to let a press overwrite an unconsumed word.
module input_port #(
   parameter int DEBOUNCE_CYCLES = 10,
   parameter int BTN_WIDTH       = 3,
   parameter int SW_WIDTH        = 9,
   parameter int DATA_WIDTH      = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [BTN_WIDTH-1:0]  btn,
   input  logic [SW_WIDTH-1:0]   sw,
   output logic [BTN_WIDTH-1:0]  btn_level,
   output logic [BTN_WIDTH-1:0]  btn_press,
   output logic [SW_WIDTH-1:0]   sw_level,
   output logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_valid,
   input  logic                  in_ready,
   output logic                  overrun
);

   localparam int N     = BTN_WIDTH + SW_WIDTH;
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   logic [N-1:0]         raw;
   logic [N-1:0]         s1_reg;
   logic [N-1:0]         s2_reg;
   logic [N-1:0]         level;
   logic [BTN_WIDTH-1:0] rise;

   assign raw = {sw, btn};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_reg <= '0;
         s2_reg <= '0;
      end else begin
         s1_reg <= raw;
         s2_reg <= s1_reg;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_bit
         logic [CNT_W-1:0] cnt_reg;
         logic             level_reg;
         logic             flip;

         // The counter only runs while s2 disagrees with the level; the last count flips it.
         assign flip = (s2_reg[gi] != level_reg) && (cnt_reg == CNT_LAST);

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               cnt_reg   <= '0;
               level_reg <= 1'b0;
            end else if ((s2_reg[gi] == level_reg) || flip) begin
               cnt_reg   <= '0;
               level_reg <= level_reg ^ flip;
            end else begin
               cnt_reg   <= cnt_reg + 1'b1;
            end
         end

         assign level[gi] = level_reg;

         if (gi < BTN_WIDTH) begin : g_strobe
            logic rise_reg;
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) rise_reg <= 1'b0;
               else        rise_reg <= flip && !level_reg;
            end
            assign rise[gi] = rise_reg;
         end
      end
   endgenerate

   assign btn_level = level[BTN_WIDTH-1:0];
   assign sw_level  = level[N-1:BTN_WIDTH];
   assign btn_press = rise;

   // Holding register
   state_t                state_reg;
   state_t                state_next;
   logic [DATA_WIDTH-1:0] data_reg;
   logic [DATA_WIDTH-1:0] data_next;
   logic [DATA_WIDTH-1:0] load_word;
   logic                  press0;

   assign press0 = btn_press[0];

`ifdef INPUT_PORT_OVERRUN_EN
   logic overrun_reg;
   logic overrun_next;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= EMPTY;
         data_reg    <= '0;
`ifdef INPUT_PORT_OVERRUN_EN
         overrun_reg <= 1'b0;
`endif
      end else begin
         state_reg   <= state_next;
         data_reg    <= data_next;
`ifdef INPUT_PORT_OVERRUN_EN
         overrun_reg <= overrun_next;
`endif
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         EMPTY:   if (press0) state_next = FULL;
         FULL:    if (in_ready && !press0) state_next = EMPTY;
         default: state_next = EMPTY;
      endcase
   end

   always_comb begin
      load_word                 = '0;
      load_word[SW_WIDTH-1:0]   = sw_level;
      data_next                 = data_reg;
`ifdef INPUT_PORT_OVERRUN_EN
      overrun_next = overrun_reg;
      if (state_reg == FULL && in_ready) overrun_next = 1'b0;
      if (state_reg == FULL && press0 && !in_ready) overrun_next = 1'b1;
      if (press0) data_next = load_word;
`else
      // A press while FULL without a same-cycle accept is discarded.
      if (press0 && (state_reg == EMPTY || in_ready)) data_next = load_word;
`endif
   end

   assign in_valid = (state_reg == FULL);
   assign in_data  = data_reg;
`ifdef INPUT_PORT_OVERRUN_EN
   assign overrun  = overrun_reg;
`else
   assign overrun  = 1'b0;
`endif

endmodule

// File: tb/tb_input_port.sv
// Directed bench for input_port: reset, glitch rejection, a table of press/handshake
// vectors and an asynchronous reset while FULL.
module tb_input_port;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  btn;
   logic [8:0]  sw;
   logic [2:0]  btn_level;
   logic [2:0]  btn_press;
   logic [8:0]  sw_level;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic        overrun;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   input_port #(
      .DEBOUNCE_CYCLES(10),
      .BTN_WIDTH(3),
      .SW_WIDTH(9),
      .DATA_WIDTH(16)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .btn(btn),
      .sw(sw),
      .btn_level(btn_level),
      .btn_press(btn_press),
      .sw_level(sw_level),
      .in_data(in_data),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .overrun(overrun)
   );

`ifdef INPUT_PORT_OVERRUN_EN
   localparam logic [15:0] OVR_DATA = 16'h00A5;
   localparam logic        OVR_FLAG = 1'b1;
`else
   localparam logic [15:0] OVR_DATA = 16'h0008;
   localparam logic        OVR_FLAG = 1'b0;
`endif

   typedef struct {
      logic        press;
      logic [8:0]  sw;
      logic        ready;
      logic        exp_valid;
      logic [15:0] exp_data;
      logic        exp_ovr;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int  seen;
      int  press_cnt;
      logic lvl_seen;

      vecs[0] = '{1'b1, 9'h008, 1'b0, 1'b1, 16'h0008, 1'b0};
      vecs[1] = '{1'b0, 9'h000, 1'b0, 1'b1, 16'h0008, 1'b0};
      vecs[2] = '{1'b0, 9'h000, 1'b1, 1'b0, 16'h0008, 1'b0};
      vecs[3] = '{1'b0, 9'h000, 1'b1, 1'b0, 16'h0008, 1'b0};
      vecs[4] = '{1'b1, 9'h008, 1'b0, 1'b1, 16'h0008, 1'b0};
      vecs[5] = '{1'b1, 9'h0A5, 1'b0, 1'b1, OVR_DATA, OVR_FLAG};
      vecs[6] = '{1'b0, 9'h000, 1'b1, 1'b0, OVR_DATA, 1'b0};
      vecs[7] = '{1'b1, 9'h011, 1'b0, 1'b1, 16'h0011, 1'b0};
      vecs[8] = '{1'b1, 9'h1FF, 1'b1, 1'b1, 16'h01FF, 1'b0};
      vecs[9] = '{1'b0, 9'h000, 1'b1, 1'b0, 16'h01FF, 1'b0};

      // Reset with everything held high
      rst_n    = 1'b0;
      btn      = 3'b111;
      sw       = 9'h1FF;
      in_ready = 1'b0;
      tick(3);
      check("rst_btn_level", btn_level, 3'b000);
      check("rst_btn_press", btn_press, 3'b000);
      check("rst_sw_level",  sw_level,  9'h000);
      check("rst_in_valid",  in_valid,  1'b0);
      check("rst_in_data",   in_data,   16'h0000);
      check("rst_overrun",   overrun,   1'b0);
      rst_n = 1'b1;
      tick(11);
      check("pre_press_edge11", btn_press, 3'b000);
      tick(1);
      check("press_edge12",    btn_press, 3'b111);
      check("level_edge12",    btn_level, 3'b111);
      check("sw_level_edge12", sw_level,  9'h1FF);
      tick(1);
      check("press_one_cycle", btn_press, 3'b000);
      check("load_after_rst",  in_data,   16'h01FF);
      check("valid_after_rst", in_valid,  1'b1);
      $display("reset sequence: level=%b sw=%h data=%h", btn_level, sw_level, in_data);
      in_ready = 1'b1;
      tick(1);
      in_ready = 1'b0;
      check("consume_valid", in_valid, 1'b0);
      check("consume_data",  in_data,  16'h01FF);
      btn = 3'b000;
      sw  = 9'h000;
      tick(12);
      check("release_level",    btn_level, 3'b000);
      check("release_no_press", btn_press, 3'b000);
      check("release_sw_level", sw_level,  9'h000);
      tick(3);

      // Glitch of 9 cycles must be rejected
      seen = 0;
      btn[1] = 1'b1;
      for (int i = 0; i < 9; i++) begin
         tick(1);
         seen += int'(btn_level[1] | btn_press[1]);
      end
      btn[1] = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick(1);
         seen += int'(btn_level[1] | btn_press[1]);
      end
      check("glitch9_rejected", seen, 0);
      $display("glitch 9 cycles: activity=%0d", seen);

      // Ten stable cycles must register, with exactly one strobe
      press_cnt = 0;
      lvl_seen  = 1'b0;
      btn[1] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         press_cnt += int'(btn_press[1]);
         lvl_seen  |= btn_level[1];
      end
      btn[1] = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick(1);
         press_cnt += int'(btn_press[1]);
         lvl_seen  |= btn_level[1];
      end
      check("hold10_press_count", press_cnt, 1);
      check("hold10_level_rose",  lvl_seen,  1'b1);
      $display("hold 10 cycles: strobes=%0d level_seen=%0b", press_cnt, lvl_seen);
      tick(5);

      // Table of press / handshake vectors
      for (int v = 0; v < 10; v++) begin
         if (vecs[v].press) begin
            btn[0] = 1'b1;
            sw     = vecs[v].sw;
            tick(12);
            check($sformatf("vec%0d_press", v), btn_press[0], 1'b1);
            in_ready = vecs[v].ready;
            tick(1);
            in_ready = 1'b0;
         end else begin
            in_ready = vecs[v].ready;
            tick(1);
            in_ready = 1'b0;
         end
         check($sformatf("vec%0d_valid", v), in_valid, vecs[v].exp_valid);
         check($sformatf("vec%0d_data", v),  in_data,  vecs[v].exp_data);
         check($sformatf("vec%0d_ovr", v),   overrun,  vecs[v].exp_ovr);
         $display("vec %0d: press=%0b ready=%0b valid=%0b data=%h ovr=%0b",
                  v, vecs[v].press, vecs[v].ready, in_valid, in_data, overrun);
         if (vecs[v].press) begin
            btn[0] = 1'b0;
            tick(14);
         end
      end

      // Asynchronous reset while FULL, button still held
      btn[0] = 1'b1;
      sw     = 9'h055;
      tick(13);
      check("full_before_rst_valid", in_valid, 1'b1);
      check("full_before_rst_data",  in_data,  16'h0055);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", in_valid,  1'b0);
      check("async_rst_data",  in_data,   16'h0000);
      check("async_rst_level", btn_level, 3'b000);
      $display("async reset: valid=%0b data=%h", in_valid, in_data);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick(11);
      check("held_btn_no_early_press", btn_press[0], 1'b0);
      tick(1);
      check("held_btn_fresh_press", btn_press[0], 1'b1);
      $display("post-reset held button: press=%b", btn_press);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/input_port.md
# input_port

Debounced, synchronised front end for the board's push-buttons and slide switches, feeding the processor's input path inside `top`. Each raw `btn`/`sw` bit is double-flop synchronised and debounced; `btn[0]` presses capture the debounced switch word into a one-entry holding register offered to the CPU over a valid/ready handshake. The other buttons are exported as debounced levels and one-cycle press strobes.

## Interface
- `DEBOUNCE_CYCLES`, 10: consecutive stable cycles required before a debounced level changes; legal range 1 and up.
- `BTN_WIDTH`, 3: number of push-buttons.
- `SW_WIDTH`, 9: number of slide switches.
- `DATA_WIDTH`, 16: width of the word presented to the CPU; must be at least `SW_WIDTH`.

Ports:
- `clk` in 1: system clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `btn` in `BTN_WIDTH`: raw push-buttons, asynchronous, active-high.
- `sw` in `SW_WIDTH`: raw slide switches, asynchronous.
- `btn_level` out `BTN_WIDTH`: debounced button levels.
- `btn_press` out `BTN_WIDTH`: one-cycle strobe on each debounced 0→1 transition.
- `sw_level` out `SW_WIDTH`: debounced switch levels.
- `in_data` out `DATA_WIDTH`: captured switch word, zero-extended.
- `in_valid` out 1: `in_data` holds an unconsumed word.
- `in_ready` in 1: CPU accepts the word on a cycle where `in_valid` is also high.
- `overrun` out 1: sticky flag; a word was overwritten before it was consumed.

## Operation
- **Reset.** While `rst_n`=0, all synchroniser flops, counters, levels and outputs are 0 and the holding register is EMPTY.
- **Synchroniser.** Per bit, two flops: `raw → s1 → s2`.
- **Debounce counter.** Per bit, width `$clog2(DEBOUNCE_CYCLES+1)`.
  - If `s2` == level: the counter clears to 0.
  - Otherwise it increments.
  - On the edge where it would reach `DEBOUNCE_CYCLES`, the level toggles and the counter clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles (measured at `s2`) never changes the level.
- **Press strobe.** `btn_press[i]` = level rose this cycle. It is registered, high exactly one cycle, and coincides with the first cycle of `btn_level[i]`=1. A release produces no strobe.
- **Holding register FSM**, states EMPTY and FULL:
  - EMPTY, `btn_press[0]`: `in_data` ← `{0, sw_level}`; go to FULL.
  - FULL, `in_ready`=1, no press: the word is consumed; go to EMPTY.
  - FULL, `in_ready`=1 and `btn_press[0]` in the same cycle: consume the old word, load the new one, stay FULL, no overrun.
  - FULL, `btn_press[0]`, `in_ready`=0: behaviour is set under Configuration.
- `in_valid` = (state == FULL). It is registered.
- `in_data` holds its value after consumption; it changes only on a load.

## Timing
- Raw bit change, held stable: the debounced level changes on the `DEBOUNCE_CYCLES+2`-th rising edge after the change is sampled into `s1`.
- `in_valid` rises on the edge after the `btn_press[0]` cycle (1-cycle latency).
- Switch value used for a load is `sw_level` in the `btn_press[0]` cycle.
- Handshake:
  - Transfer occurs on a rising edge where `in_valid` && `in_ready`.
  - `in_valid` is low in the following cycle unless a reload occurred.
  - `in_ready` while EMPTY is ignored.
- Reset asserted mid-debounce or while FULL: state is lost immediately (asynchronous). After release, levels rebuild from 0, so a button still held produces a fresh press strobe `DEBOUNCE_CYCLES+2` cycles later.

## Configuration
- `INPUT_PORT_OVERRUN_EN` defined:
  - A press while FULL with `in_ready`=0 overwrites `in_data` with the new `sw_level` and sets `overrun`=1.
  - `overrun` clears on the next accepted transfer; if a set and a clear fall on the same edge, set wins.
- Not defined:
  - A press while FULL with `in_ready`=0 is dropped and `in_data` is unchanged.
  - `overrun` is constant 0.

## Test plan
- **Reset values.** Reset with `btn`=3'b111, `sw`=9'h1FF → all outputs 0 during reset. After release: `btn_press`=3'b111 for one cycle at edge 12 (`DEBOUNCE_CYCLES`=10), then `sw_level`=9'h1FF.
- **Glitch rejection.** Pulse `btn[1]` high for 9 cycles → `btn_level[1]` and `btn_press[1]` stay 0. Hold it for 10 cycles → level rises, one strobe.
- **Load and handshake.** `sw`=9'h008, press `btn[0]`, `in_ready`=0 → `in_valid`=1 and `in_data`=16'h0008, held. Assert `in_ready` for one cycle → `in_valid`=0 next cycle, `in_data` still 16'h0008.
- **Second press while FULL.**
  - Set-up: `sw` changed to 9'h0A5, second press while `in_ready`=0.
  - With `INPUT_PORT_OVERRUN_EN`: `in_data`=16'h00A5 and `overrun`=1, which clears after the next accept.
  - Without it: `in_data` stays 16'h0008 and `overrun`=0.
- **Simultaneous accept and press.** `in_ready`=1 in the `btn_press[0]` cycle while FULL → `in_valid` stays 1, new data loaded, `overrun`=0.
- **Reset mid-operation.** Assert `rst_n`=0 while FULL → `in_valid`=0 and `in_data`=0 asynchronously, within the same cycle.
